// File: rtl/ext_mem_model_param_pkg.sv
// Shared constants, write-FSM encoding and LFSR step for the external memory model.
package ext_mem_model_param_pkg;

    localparam int MEM_DATA_BITS = 128;
    localparam int MEM_ADDR_BITS = 28;
    localparam int MEM_TAG_BITS  = 5;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WDATA = 1'b1
    } wr_state_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {cur[14:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/ext_mem_model_param_if.sv
// Request / write-data / response bundle between the core harness and the memory model.
interface ext_mem_model_param_if
    import ext_mem_model_param_pkg::*;
#(
    parameter int DATA_BITS = MEM_DATA_BITS,
    parameter int ADDR_BITS = MEM_ADDR_BITS,
    parameter int TAG_BITS  = MEM_TAG_BITS
);
    logic                   mem_req_valid;
    logic                   mem_req_ready;
    logic                   mem_req_rw;
    logic [ADDR_BITS-1:0]   mem_req_addr;
    logic [TAG_BITS-1:0]    mem_req_tag;
    logic                   mem_req_data_valid;
    logic                   mem_req_data_ready;
    logic [DATA_BITS-1:0]   mem_req_data_bits;
    logic [DATA_BITS/8-1:0] mem_req_data_mask;
    logic                   mem_resp_valid;
    logic [TAG_BITS-1:0]    mem_resp_tag;
    logic [DATA_BITS-1:0]   mem_resp_data;

    modport master (
        output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_tag,
               mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
        input  mem_req_ready, mem_req_data_ready,
               mem_resp_valid, mem_resp_tag, mem_resp_data
    );

    modport slave (
        input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_tag,
               mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
        output mem_req_ready, mem_req_data_ready,
               mem_resp_valid, mem_resp_tag, mem_resp_data
    );
endinterface

// File: rtl/mem_model_delay_pipe.sv
// Fixed-length shift register carrying {valid, payload}; only the valid chain is cleared.
module mem_model_delay_pipe #(
    parameter int LATENCY = 4,
    parameter int W       = 8
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         in_valid,
    input  logic [W-1:0] in_bits,
    output logic         out_valid,
    output logic [W-1:0] out_bits
);
    logic [LATENCY-1:0] valid_q;
    logic [W-1:0]       bits_q [LATENCY];

    // valid chain, dropped entirely on clear so in-flight responses vanish
    always_ff @(posedge clk) begin
        if (clear) begin
            valid_q <= '0;
        end else begin
            valid_q[0] <= in_valid;
            for (int i = 1; i < LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
            end
        end
    end

    // payload chain; contents are don't-care whenever the matching valid is low
    always_ff @(posedge clk) begin
        bits_q[0] <= in_bits;
        for (int i = 1; i < LATENCY; i++) begin
            bits_q[i] <= bits_q[i-1];
        end
    end

    assign out_valid = valid_q[LATENCY-1];
    assign out_bits  = bits_q[LATENCY-1];
endmodule

// File: rtl/ext_mem_model_param.sv
// Cycle-accurate external memory model: fixed read latency, byte-masked writes,
// optional LFSR-driven request back-pressure and transaction counters.
module ext_mem_model_param
    import ext_mem_model_param_pkg::*;
#(
    parameter int          DATA_BITS  = MEM_DATA_BITS,
    parameter int          ADDR_BITS  = MEM_ADDR_BITS,
    parameter int          TAG_BITS   = MEM_TAG_BITS,
    parameter int          DEPTH_LOG2 = 20,
    parameter int          LATENCY    = 4,
    parameter int          STALL_EN   = 0,
    parameter int          STALL_BITS = 2,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic                       clk,
    input  logic                       reset,
    ext_mem_model_param_if.slave       mem,
    output logic [31:0]                rd_count,
    output logic [31:0]                wr_count
);
    localparam int MASK_BITS = DATA_BITS / 8;
    localparam int PW        = TAG_BITS + DATA_BITS;

    logic [DATA_BITS-1:0]  ram [2**DEPTH_LOG2];
    wr_state_t             state;
    logic [DEPTH_LOG2-1:0] w_index;
    logic [DEPTH_LOG2-1:0] r_index;
    logic [15:0]           lfsr;
    logic                  stall;
    logic                  req_fire;
    logic                  rd_fire;
    logic                  data_fire;
    logic                  pipe_valid;
    logic [PW-1:0]         pipe_bits;
    logic                  resp_live;
    logic                  unused_addr_bits;

    // upper address bits alias onto the same ram entries
    assign r_index          = mem.mem_req_addr[DEPTH_LOG2-1:0];
    assign unused_addr_bits = ^mem.mem_req_addr;

    assign stall                  = (STALL_EN != 0) && (lfsr[STALL_BITS-1:0] == '0);
    assign mem.mem_req_ready      = ~reset & ~stall & (state == ST_IDLE);
    assign mem.mem_req_data_ready = ~reset & (state == ST_WDATA);

    assign req_fire  = mem.mem_req_valid & mem.mem_req_ready;
    assign rd_fire   = req_fire & ~mem.mem_req_rw;
    assign data_fire = mem.mem_req_data_valid & mem.mem_req_data_ready;

    // write FSM: a write request parks here until its data beat arrives
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            w_index <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_fire && mem.mem_req_rw) begin
                        w_index <= r_index;
                        state   <= ST_WDATA;
                    end
                end
                ST_WDATA: begin
                    if (data_fire) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // back-pressure LFSR, free-running outside reset
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= SEED;
        end else begin
            lfsr <= lfsr_next(lfsr);
        end
    end

    // transaction counters, wrapping naturally at 2**32
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            if (rd_fire) begin
                rd_count <= rd_count + 32'd1;
            end
            if (data_fire) begin
                wr_count <= wr_count + 32'd1;
            end
        end
    end

    // byte-masked ram update; ram is never cleared so preloaded contents survive reset
    always_ff @(posedge clk) begin
        if (data_fire) begin
            for (int i = 0; i < MASK_BITS; i++) begin
                if (mem.mem_req_data_mask[i]) begin
                    ram[w_index][8*i +: 8] <= mem.mem_req_data_bits[8*i +: 8];
                end
            end
        end
    end

    mem_model_delay_pipe #(
        .LATENCY (LATENCY),
        .W       (PW)
    ) u_delay (
        .clk       (clk),
        .clear     (reset),
        .in_valid  (rd_fire),
        .in_bits   ({mem.mem_req_tag, ram[r_index]}),
        .out_valid (pipe_valid),
        .out_bits  (pipe_bits)
    );

    // responses are forced quiet during reset and zeroed when not valid
    assign resp_live          = pipe_valid & ~reset;
    assign mem.mem_resp_valid = resp_live;
    assign mem.mem_resp_tag   = resp_live ? pipe_bits[PW-1 -: TAG_BITS] : '0;
    assign mem.mem_resp_data  = resp_live ? pipe_bits[DATA_BITS-1:0] : '0;
endmodule

// File: doc/ext_mem_model_param.md
Name: ext_mem_model_param

Overview:
Parametrised, cycle-accurate external memory model for riscv_top simulation benches. It replaces the fixed-latency, always-ready memory with one that adds:
- configurable data, address and tag widths and memory depth
- configurable read latency
- byte-masked writes
- optional pseudo-random request back-pressure, for stressing the cache/miss logic
- read/write transaction counters

It sits beside riscv_top in the harness and is preloaded by $readmemh into its internal ram.

Parameters:
DATA_BITS, 128, width of one memory beat (mem_req_data_bits / mem_resp_data)
ADDR_BITS, 28, beat address width (byte address = addr << log2(DATA_BITS/8))
TAG_BITS, 5, request/response tag width
DEPTH_LOG2, 20, ram holds 2**DEPTH_LOG2 beats; address index = addr[DEPTH_LOG2-1:0]
LATENCY, 4, cycles from read accept to response; legal range 1..32
STALL_EN, 0, 1 = enable random mem_req_ready back-pressure
STALL_BITS, 2, stall when lfsr[STALL_BITS-1:0]==0 (about 1 cycle in 2**STALL_BITS)
SEED, 16'hACE1, LFSR reset value; must be nonzero

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
mem_req_valid  in  1  request valid
mem_req_ready  out  1  request accepted when valid & ready
mem_req_rw  in  1  1 = write, 0 = read
mem_req_addr  in  ADDR_BITS  beat address
mem_req_tag  in  TAG_BITS  request tag
mem_req_data_valid  in  1  write data valid
mem_req_data_ready  out  1  write data accepted when valid & ready
mem_req_data_bits  in  DATA_BITS  write data
mem_req_data_mask  in  DATA_BITS/8  byte write enables
mem_resp_valid  out  1  read response valid; single-cycle pulse; no back-pressure
mem_resp_tag  out  TAG_BITS  tag of the response
mem_resp_data  out  DATA_BITS  read data
rd_count  out  32  accepted reads since reset
wr_count  out  32  completed writes since reset

Behaviour:
- Reset (synchronous):
  - write FSM goes to IDLE; latency pipeline valids clear; lfsr loads SEED; counters clear.
  - mem_resp_valid/tag/data are 0.
  - mem_req_ready and mem_req_data_ready are 0 while reset is high.
  - ram contents are preserved across reset.
- Write FSM states:
  - IDLE: mem_req_ready = ~reset & ~stall; mem_req_data_ready = 0.
    - Read handshake: stays in IDLE.
    - Write handshake: latches index and tag, goes to WDATA.
  - WDATA: mem_req_ready = 0; mem_req_data_ready = 1.
    - On data handshake: ram[index] updated per byte, byte i written iff mask[i]; wr_count++; returns to IDLE.
    - Write data arriving before its request is held off (data_ready = 0 in IDLE).
- stall = STALL_EN & (lfsr[STALL_BITS-1:0]==0).
  - lfsr is a 16-bit Fibonacci LFSR, taps 16,14,13,11; it advances every cycle reset is low.
  - With STALL_EN=0, stall is always 0.
- Reads:
  - On a read handshake in cycle t, ram[index] is read at that edge and enters the delay pipeline with its tag; rd_count++.
  - mem_resp_valid is high in exactly cycle t+LATENCY, with that tag and data.
  - Back-to-back reads in consecutive cycles give back-to-back responses, in order. Throughput is 1 read/cycle.
- Ordering and hazards:
  - A write completes before any later request is accepted, so a read accepted after a write's data handshake returns the new data.
  - Writes produce no response.
- Addresses: bits above DEPTH_LOG2 are ignored (wrap-around aliasing).
- Counters wrap at 2**32.
- Reset mid-operation:
  - An in-flight read's response is dropped.
  - A write in WDATA is abandoned and ram is not modified.

Decomposition:
- Shared constants: MEM_DATA_BITS, MEM_ADDR_BITS and MEM_TAG_BITS come from const.vh and serve as parameter defaults at instantiation.
- The LFSR tap constant and the FSM state encodings (IDLE=1'b0, WDATA=1'b1) go in a shared mem_model_const.vh include.
- One sub-module: mem_model_delay_pipe (parameters LATENCY, W). It is a LATENCY-stage shift register of {valid, tag, data} with synchronous clear of the valid bits.

Test Plan:
- LATENCY=4, STALL_EN=0: preload ram[0x10]=128'h1; read addr 0x10 tag 3 in cycle 10 -> mem_resp_valid only in cycle 14, tag 3, data 128'h1; rd_count=1.
- Write addr 0x20, data all-ones, mask 16'h00FF over prior ram value 0 -> next read of 0x20 returns 128'h0000..00FF..FF (low 8 bytes set); wr_count=1; mem_req_ready=0 while in WDATA.
- 8 back-to-back reads with tags 0..7 -> 8 consecutive response cycles, tags 0..7 in order, no gaps.
- DEPTH_LOG2=4: write addr 0x13, then read addr 0x03 -> returns the written data (aliasing).
- STALL_EN=1, STALL_BITS=2: 1000 random requests -> mem_req_ready low on some cycles; every accepted read gets exactly one response LATENCY cycles later; counters match the bench scoreboard.
- Assert reset 2 cycles after a read is accepted (LATENCY=4) -> no mem_resp_valid after reset; all outputs 0 during reset; ram is unchanged afterwards.
